hbmc_bus_sync_mux: RTL and testbench

- Multi-channel successor to the single-channel bus handshake synchronizer.
- Accepts C_CHANNELS independent 4-phase req/ack source interfaces. The src_req lines may be asynchronous to clk.
- Captures each channel's data word and arbitrates the captured words onto one downstream valid/ready port.
- Sits between slow control/config producers (other clock domains) and the HBMC command path, all in the clk domain.

---
 rtl/hbmc_bus_sync_mux.sv | 191 +++++++++++++++++++
 tb/tb_hbmc_bus_sync_mux.sv | 340 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/hbmc_bus_sync_mux.sv
// hbmc_bus_sync_mux
// Multi-channel 4-phase req/ack synchronizer and arbiter. Each channel
// resynchronizes its src_req, captures its data word into a hold register,
// and competes for a one-deep valid/ready output register. src_ack rises
// once the word has been accepted downstream. It falls again once the
// synchronized request has dropped.
// Build option: define HBMC_BUS_SYNC_MUX_FIXED_PRIO_EN for fixed-priority
// arbitration (lowest pending channel wins, no pointer register). When the
// macro is undefined, arbitration is round-robin.
module hbmc_bus_sync_mux #(
  parameter int C_CHANNELS    = 4,
  parameter int C_DATA_WIDTH  = 8,
  parameter int C_SYNC_STAGES = 3,
  localparam int C_CHAN_W     = (C_CHANNELS > 1) ? $clog2(C_CHANNELS) : 1
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic [C_CHANNELS*C_DATA_WIDTH-1:0] src_data,
  input  logic [C_CHANNELS-1:0]             src_req,
  output logic [C_CHANNELS-1:0]             src_ack,
  output logic [C_DATA_WIDTH-1:0]           dst_data,
  output logic [C_CHAN_W-1:0]               dst_chan,
  output logic                              dst_valid,
  input  logic                              dst_ready
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_PEND = 2'd1,
    ST_WAIT = 2'd2,
    ST_ACK  = 2'd3
  } state_t;

  logic [C_CHANNELS-1:0]              req_sync;
  logic [C_CHANNELS-1:0]              pend;
  logic [C_CHANNELS*C_DATA_WIDTH-1:0] hold_flat;

  logic                    dst_valid_reg;
  logic [C_DATA_WIDTH-1:0] dst_data_reg;
  logic [C_CHAN_W-1:0]     dst_chan_reg;

  logic                    accept;
  logic                    out_free;
  logic                    grant_vld;
  logic [C_CHAN_W-1:0]     grant_idx;

  // The output register can take a new word when empty or when its current
  // word leaves on this same edge.
  assign accept   = dst_valid_reg & dst_ready;
  assign out_free = ~dst_valid_reg | dst_ready;

  genvar gi;
  generate
    for (gi = 0; gi < C_CHANNELS; gi++) begin : g_chan
      logic [C_SYNC_STAGES-1:0] sync_reg;
      state_t                   state_reg;
      logic                     ack_reg;
      logic [C_DATA_WIDTH-1:0]  hold_reg;
      logic                     grant_me;
      logic                     accept_me;

      // The only path from src_req into the logic: a plain flop chain.
      always_ff @(posedge clk) begin
        if (rst) begin
          sync_reg <= '0;
        end else begin
          sync_reg <= {sync_reg[C_SYNC_STAGES-2:0], src_req[gi]};
        end
      end

      assign req_sync[gi] = sync_reg[C_SYNC_STAGES-1];
      assign grant_me     = grant_vld && (grant_idx == C_CHAN_W'(gi));
      assign accept_me    = accept && (dst_chan_reg == C_CHAN_W'(gi));

      // Per-channel handshake. A new capture only happens from IDLE, so a
      // request held high after its ack cannot produce a second word.
      always_ff @(posedge clk) begin
        if (rst) begin
          state_reg <= ST_IDLE;
          ack_reg   <= 1'b0;
          hold_reg  <= '0;
        end else begin
          case (state_reg)
            ST_IDLE: begin
              if (req_sync[gi]) begin
                hold_reg  <= src_data[gi*C_DATA_WIDTH +: C_DATA_WIDTH];
                state_reg <= ST_PEND;
              end
            end
            ST_PEND: begin
              if (grant_me) begin
                state_reg <= ST_WAIT;
              end
            end
            ST_WAIT: begin
              if (accept_me) begin
                ack_reg   <= 1'b1;
                state_reg <= ST_ACK;
              end
            end
            ST_ACK: begin
              if (!req_sync[gi]) begin
                ack_reg   <= 1'b0;
                state_reg <= ST_IDLE;
              end
            end
            default: begin
              state_reg <= ST_IDLE;
            end
          endcase
        end
      end

      assign pend[gi]                                     = (state_reg == ST_PEND);
      assign src_ack[gi]                                  = ack_reg;
      assign hold_flat[gi*C_DATA_WIDTH +: C_DATA_WIDTH]   = hold_reg;
    end
  endgenerate

`ifdef HBMC_BUS_SYNC_MUX_FIXED_PRIO_EN
  // Fixed priority: scan from the top so the lowest pending index is the
  // last one written and therefore wins.
  always_comb begin
    grant_vld = 1'b0;
    grant_idx = '0;
    for (int i = C_CHANNELS - 1; i >= 0; i--) begin
      if (pend[i]) begin
        grant_vld = 1'b1;
        grant_idx = C_CHAN_W'(i);
      end
    end
    if (!out_free) begin
      grant_vld = 1'b0;
    end
  end
`else
  logic [C_CHAN_W-1:0] ptr_reg;
  logic [C_CHAN_W:0]   rr_idx;

  // Round-robin: scan offsets from the highest down, so the smallest
  // offset from the pointer that is pending is the last one written.
  always_comb begin
    grant_vld = 1'b0;
    grant_idx = '0;
    rr_idx    = '0;
    for (int i = C_CHANNELS - 1; i >= 0; i--) begin
      rr_idx = {1'b0, ptr_reg} + (C_CHAN_W + 1)'(i);
      if (rr_idx >= (C_CHAN_W + 1)'(C_CHANNELS)) begin
        rr_idx = rr_idx - (C_CHAN_W + 1)'(C_CHANNELS);
      end
      if (pend[rr_idx[C_CHAN_W-1:0]]) begin
        grant_vld = 1'b1;
        grant_idx = rr_idx[C_CHAN_W-1:0];
      end
    end
    if (!out_free) begin
      grant_vld = 1'b0;
    end
  end

  // The pointer moves to the channel after the one just granted.
  always_ff @(posedge clk) begin
    if (rst) begin
      ptr_reg <= '0;
    end else if (grant_vld) begin
      ptr_reg <= (grant_idx == C_CHAN_W'(C_CHANNELS - 1)) ? '0 : grant_idx + 1'b1;
    end
  end
`endif

  // One-deep output register. A grant and an acceptance may happen on the
  // same edge. Data and channel only change on a grant.
  always_ff @(posedge clk) begin
    if (rst) begin
      dst_valid_reg <= 1'b0;
      dst_data_reg  <= '0;
      dst_chan_reg  <= '0;
    end else if (grant_vld) begin
      dst_valid_reg <= 1'b1;
      dst_data_reg  <= hold_flat[grant_idx*C_DATA_WIDTH +: C_DATA_WIDTH];
      dst_chan_reg  <= grant_idx;
    end else if (accept) begin
      dst_valid_reg <= 1'b0;
    end
  end

  assign dst_valid = dst_valid_reg;
  assign dst_data  = dst_data_reg;
  assign dst_chan  = dst_chan_reg;

endmodule

// File: tb/tb_hbmc_bus_sync_mux.sv
// Testbench for hbmc_bus_sync_mux. The reference model works at the
// transaction level: it uses the latency rules for capture, grant and ack
// timing, plus an abstract arbitration search over pending words.
module tb_hbmc_bus_sync_mux;

  localparam int CH = 4;
  localparam int DW = 8;
  localparam int SS = 3;
  localparam int CW = 2;

  logic              clk = 1'b0;
  logic              rst;
  logic [CH*DW-1:0]  src_data;
  logic [CH-1:0]     src_req;
  logic [CH-1:0]     src_ack;
  logic [DW-1:0]     dst_data;
  logic [CW-1:0]     dst_chan;
  logic              dst_valid;
  logic              dst_ready;

  always #5 clk = ~clk;

  hbmc_bus_sync_mux #(
    .C_CHANNELS   (CH),
    .C_DATA_WIDTH (DW),
    .C_SYNC_STAGES(SS)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .src_data (src_data),
    .src_req  (src_req),
    .src_ack  (src_ack),
    .dst_data (dst_data),
    .dst_chan (dst_chan),
    .dst_valid(dst_valid),
    .dst_ready(dst_ready)
  );

  int n_checks = 0;
  int n_errors = 0;
  int edge_cnt = 0;

  // Reference model state
  logic          m_valid;
  logic [DW-1:0] m_data;
  int            m_chan;
  logic [CH-1:0] m_ack;
  int            m_ptr;
  logic [CH-1:0] m_pend;
  int            m_elig[CH];
  logic [DW-1:0] m_word[CH];
  int            m_ack_clr[CH];
  logic [CH-1:0] req_prev;

  // Observation and source state
  logic          obs_prev_valid;
  int            grant_cnt[CH];
  int            q_chan[$];
  int            q_edge[$];
  logic          track;
  int            sstate[CH];
  logic [CH-1:0] auto_mask;
  logic [CH-1:0] hold_mask;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (edge %0d)", tag, obs, exp, edge_cnt);
    end
  endtask

  // Advance the model over edge edge_cnt, given the inputs present at that edge.
  task automatic model_edge(input logic rst_at, input logic [CH-1:0] req_at, input logic rdy_at);
    logic acc;
    logic fr;
    int   g;
    int   c;
    if (rst_at) begin
      m_valid = 1'b0;
      m_data  = '0;
      m_chan  = 0;
      m_ack   = '0;
      m_ptr   = 0;
      m_pend  = '0;
      for (int n = 0; n < CH; n++) begin
        m_ack_clr[n] = -1;
        if (req_at[n]) begin
          m_pend[n] = 1'b1;
          m_elig[n] = edge_cnt + SS + 2;
          m_word[n] = src_data[n*DW +: DW];
        end
      end
    end else begin
      acc = m_valid && rdy_at;
      fr  = !m_valid || rdy_at;
      if (acc) m_ack[m_chan] = 1'b1;
      g = -1;
      if (fr) begin
        for (int k = 0; k < CH; k++) begin
`ifdef HBMC_BUS_SYNC_MUX_FIXED_PRIO_EN
          c = k;
`else
          c = (m_ptr + k) % CH;
`endif
          if (g < 0 && m_pend[c] && m_elig[c] <= edge_cnt) g = c;
        end
      end
      if (g >= 0) begin
        m_valid   = 1'b1;
        m_chan    = g;
        m_data    = m_word[g];
        m_pend[g] = 1'b0;
        m_ptr     = (g + 1) % CH;
      end else if (acc) begin
        m_valid = 1'b0;
      end
      for (int n = 0; n < CH; n++) begin
        if (m_ack_clr[n] == edge_cnt) begin
          m_ack[n]     = 1'b0;
          m_ack_clr[n] = -1;
        end
        if (req_at[n] && !req_prev[n]) begin
          m_pend[n] = 1'b1;
          m_elig[n] = edge_cnt + SS + 1;
          m_word[n] = src_data[n*DW +: DW];
        end
        if (!req_at[n] && req_prev[n]) m_ack_clr[n] = edge_cnt + SS;
      end
    end
    req_prev = req_at;
  endtask

  task automatic fire(input int n, input logic [DW-1:0] d);
    src_data[n*DW +: DW] = d;
    src_req[n] = 1'b1;
    sstate[n]  = 1;
  endtask

  task automatic release_req(input int n);
    hold_mask[n] = 1'b0;
    src_req[n]   = 1'b0;
    sstate[n]    = 2;
  endtask

  // One clock: apply the edge, then sample at the falling edge. Next, update
  // the model, compare against it, and let the sources react.
  task automatic step();
    logic          rst_at;
    logic          rdy_at;
    logic [CH-1:0] req_at;
    logic          new_word;
    rst_at = rst;
    rdy_at = dst_ready;
    req_at = src_req;
    @(posedge clk);
    edge_cnt++;
    @(negedge clk);
    model_edge(rst_at, req_at, rdy_at);
    new_word = !rst_at && dst_valid && (!obs_prev_valid || rdy_at);
    if (new_word) begin
      grant_cnt[dst_chan]++;
      if (track) begin
        q_chan.push_back(int'(dst_chan));
        q_edge.push_back(edge_cnt);
      end
    end
    obs_prev_valid = dst_valid;
    check_val("dst_valid", {31'd0, dst_valid}, {31'd0, m_valid});
    check_val("src_ack", {28'd0, src_ack}, {28'd0, m_ack});
    check_val("dst_data", {24'd0, dst_data}, {24'd0, m_data});
    check_val("dst_chan", {30'd0, dst_chan}, m_chan);
    for (int n = 0; n < CH; n++) begin
      case (sstate[n])
        0: if (auto_mask[n] && $urandom_range(0, 3) == 0) fire(n, DW'($urandom_range(0, 255)));
        1: if (src_ack[n] && !hold_mask[n]) begin
             src_req[n] = 1'b0;
             sstate[n]  = 2;
           end
        2: if (!src_ack[n]) sstate[n] = 0;
        default: sstate[n] = 0;
      endcase
    end
  endtask

  task automatic drain(input string tag);
    logic done;
    auto_mask = '0;
    dst_ready = 1'b1;
    done = 1'b0;
    for (int k = 0; k < 300 && !done; k++) begin
      if (sstate[0] == 0 && sstate[1] == 0 && sstate[2] == 0 && sstate[3] == 0 &&
          !m_valid && m_pend == '0 && src_ack == '0) done = 1'b1;
      else step();
    end
    check_val(tag, {31'd0, done}, 32'd1);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int g0;
    rst = 1'b1;
    src_req = '0;
    src_data = '0;
    dst_ready = 1'b0;
    auto_mask = '0;
    hold_mask = '0;
    track = 1'b0;
    obs_prev_valid = 1'b0;
    req_prev = '0;
    for (int n = 0; n < CH; n++) begin
      sstate[n] = 0;
      grant_cnt[n] = 0;
      m_ack_clr[n] = -1;
      m_elig[n] = 0;
      m_word[n] = '0;
    end
    step();
    step();
    rst = 1'b0;
    check_val("rst_valid", {31'd0, dst_valid}, 32'd0);
    check_val("rst_ack", {28'd0, src_ack}, 32'd0);
    check_val("rst_data", {24'd0, dst_data}, 32'd0);

    // Single transfer with latency checks
    dst_ready = 1'b1;
    fire(2, 8'hA5);
    repeat (4) step();
    check_val("t1_valid_e4", {31'd0, dst_valid}, 32'd0);
    step();
    check_val("t1_valid_e5", {31'd0, dst_valid}, 32'd1);
    check_val("t1_data_e5", {24'd0, dst_data}, 32'hA5);
    check_val("t1_chan_e5", {30'd0, dst_chan}, 32'd2);
    step();
    check_val("t1_ack_e6", {31'd0, src_ack[2]}, 32'd1);
    repeat (3) step();
    check_val("t1_ack_hold", {31'd0, src_ack[2]}, 32'd1);
    step();
    check_val("t1_ack_fall", {31'd0, src_ack[2]}, 32'd0);
    drain("t1_drain");

    // Round-robin order with simultaneous requests
    do_reset();
    track = 1'b1;
    q_chan.delete();
    q_edge.delete();
    for (int n = 0; n < CH; n++) fire(n, DW'(8'h10 + n));
    repeat (12) step();
    check_val("t2_count", q_chan.size(), 32'd4);
    for (int i = 0; i < 4; i++) begin
      check_val($sformatf("t2_chan%0d", i), (i < q_chan.size()) ? q_chan[i] : -1, i);
      check_val($sformatf("t2_edge%0d", i), (i < q_edge.size() && q_edge.size() > 0) ? q_edge[i] - q_edge[0] : -1, i);
    end
    drain("t2_drain_a");
    q_chan.delete();
    q_edge.delete();
    fire(0, 8'h20);
    fire(3, 8'h23);
    repeat (12) step();
    check_val("t2b_count", q_chan.size(), 32'd2);
    check_val("t2b_first", (q_chan.size() > 0) ? q_chan[0] : -1, 32'd0);
    check_val("t2b_second", (q_chan.size() > 1) ? q_chan[1] : -1, 32'd3);
    drain("t2_drain_b");
    track = 1'b0;

    // Backpressure
    dst_ready = 1'b0;
    fire(2, 8'h5C);
    repeat (15) step();
    check_val("t3_valid_held", {31'd0, dst_valid}, 32'd1);
    check_val("t3_data_held", {24'd0, dst_data}, 32'h5C);
    check_val("t3_no_ack", {31'd0, src_ack[2]}, 32'd0);
    dst_ready = 1'b1;
    step();
    check_val("t3_ack_after", {31'd0, src_ack[2]}, 32'd1);
    drain("t3_drain");

    // No double capture while request is held
    dst_ready = 1'b1;
    hold_mask[1] = 1'b1;
    g0 = grant_cnt[1];
    fire(1, 8'h3C);
    repeat (60) step();
    check_val("t4_one_word", grant_cnt[1] - g0, 32'd1);
    check_val("t4_ack_held", {31'd0, src_ack[1]}, 32'd1);
    release_req(1);
    repeat (8) step();
    fire(1, 8'hC3);
    repeat (12) step();
    check_val("t4_two_words", grant_cnt[1] - g0, 32'd2);
    drain("t4_drain");

    // Reset while a word waits in the output register
    dst_ready = 1'b0;
    hold_mask[3] = 1'b1;
    fire(3, 8'h77);
    repeat (6) step();
    check_val("t5_wait_valid", {31'd0, dst_valid}, 32'd1);
    check_val("t5_wait_chan", {30'd0, dst_chan}, 32'd3);
    rst = 1'b1;
    step();
    rst = 1'b0;
    check_val("t5_rst_valid", {31'd0, dst_valid}, 32'd0);
    check_val("t5_rst_ack", {28'd0, src_ack}, 32'd0);
    repeat (SS + 1) step();
    check_val("t5_pre_valid", {31'd0, dst_valid}, 32'd0);
    step();
    check_val("t5_again_valid", {31'd0, dst_valid}, 32'd1);
    check_val("t5_again_chan", {30'd0, dst_chan}, 32'd3);
    check_val("t5_again_data", {24'd0, dst_data}, 32'h77);
    hold_mask[3] = 1'b0;
    dst_ready = 1'b1;
    drain("t5_drain");

    // Randomized traffic against the model
    do_reset();
    auto_mask = '1;
    for (int k = 0; k < 3000; k++) begin
      dst_ready = ($urandom_range(0, 9) < 7);
      step();
    end
    drain("rand_drain");

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
